// File: rtl/tt_rr_arbiter.sv
// tt_rr_arbiter: four-requester round-robin arbiter with hold-until-release
// grants and a watchdog that revokes grants held for TIMEOUT_CYCLES cycles.
//
// Ports (Tiny Tapeout 8-in/8-out frame):
//   io_in[0]    clk
//   io_in[1]    rst_n, synchronous active-low
//   io_in[5:2]  req[3:0], level requests
//   io_in[6]    release pulse from the current owner
//   io_in[7]    unused
//   io_out[3:0] grant (one-hot or zero)
//   io_out[5:4] owner (0 when idle)
//   io_out[6]   busy
//   io_out[7]   timeout (sticky until next grant)
module tt_rr_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 12
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT_CYCLES - 1);

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    // "release" is a reserved word, hence the short name.
    logic       rls;
    logic       unused_in;

    assign clk       = io_in[0];
    assign rst_n     = io_in[1];
    assign req       = io_in[5:2];
    assign rls       = io_in[6];
    assign unused_in = io_in[7];

    logic [0:0] state;
    logic [3:0] grant;
    logic [1:0] owner;
    logic [1:0] ptr;
    logic [3:0] cnt;
    logic       timeout;

    // Rotate req so that bit 0 is the requester at ptr, pick the first
    // set bit, then rotate the offset back into an absolute index.
    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] sel_ofs;
    logic [1:0] sel;

    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl[ptr +: 4];
        sel_ofs = 2'd0;
        if (req_rot[0]) begin
            sel_ofs = 2'd0;
        end else if (req_rot[1]) begin
            sel_ofs = 2'd1;
        end else if (req_rot[2]) begin
            sel_ofs = 2'd2;
        end else if (req_rot[3]) begin
            sel_ofs = 2'd3;
        end
        sel = ptr + sel_ofs;
    end

    logic end_rls;
    logic end_drop;
    logic end_wdog;
    logic end_any;

    always_comb begin
        end_rls  = rls;
        end_drop = ~req[owner];
        end_wdog = (cnt == CNT_LAST);
        end_any  = end_rls | end_drop | end_wdog;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            grant   <= 4'b0000;
            owner   <= 2'd0;
            ptr     <= 2'd0;
            cnt     <= 4'd0;
            timeout <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state   <= ST_GRANT;
                        grant   <= 4'b0001 << sel;
                        owner   <= sel;
                        cnt     <= 4'd0;
                        timeout <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (end_any) begin
                        state   <= ST_IDLE;
                        grant   <= 4'b0000;
                        owner   <= 2'd0;
                        ptr     <= owner + 2'd1;
                        cnt     <= 4'd0;
                        // A watchdog hit that coincides with a normal
                        // end is reported as a normal release.
                        timeout <= end_wdog & ~end_rls & ~end_drop;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_out = {timeout, |grant, owner, grant};

endmodule
